// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_ASR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_ASR) || (op == OP_LSL) || (op == OP_LSR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of a WIDTH-bit value; also reports the bit that leaves the word.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    always_comb begin
        shifted = value;
        bit_out = 1'b0;
        case (op)
            OP_ASR: begin shifted = {value[WIDTH-1], value[WIDTH-1:1]}; bit_out = value[0];       end
            OP_LSL: begin shifted = {value[WIDTH-2:0], 1'b0};           bit_out = value[WIDTH-1]; end
            OP_LSR: begin shifted = {1'b0, value[WIDTH-1:1]};           bit_out = value[0];       end
            OP_ROL: begin shifted = {value[WIDTH-2:0], value[WIDTH-1]}; bit_out = value[WIDTH-1]; end
            OP_ROR: begin shifted = {value[0], value[WIDTH-1:1]};       bit_out = value[0];       end
            default: begin shifted = value; bit_out = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/done handshake; shifts and rotates run one bit per cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         Op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   Out,
    output logic               Zero,
    output logic               Carry,
    output logic               Overflow,
    output logic               Negative,
    output logic               Err
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   step_val;
    logic               step_bit;
    logic               start_shift;
    logic               last_step;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err;

    assign ready       = (state == IDLE);
    assign start_shift = is_shift(Op) && (shamt != '0);
    assign last_step   = (cnt == SHAMT_W'(1));
    assign sum_w       = {1'b0, A} + {1'b0, B};
    assign diff_w      = {1'b0, A} - {1'b0, B};

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (work),
        .op      (op_q),
        .shifted (step_val),
        .bit_out (step_bit)
    );

    // Single-cycle result path; also covers shifts by zero, which pass A through.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_NOT: alu_res = ~A;
            OP_ASR, OP_LSL, OP_LSR, OP_ROL, OP_ROR: alu_res = A;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && start_shift) state_nxt = SHIFT;
            SHIFT:   if (last_step)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            Out      <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
            Err      <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            op_q     <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (start_shift) begin
                    work <= A;
                    cnt  <= shamt;
                    op_q <= Op;
                end else begin
                    Out      <= alu_res;
                    Zero     <= (alu_res == '0);
                    Carry    <= alu_c;
                    Overflow <= alu_v;
                    Negative <= alu_res[WIDTH-1];
                    Err      <= alu_err;
                    done     <= 1'b1;
                end
            end else if (state == SHIFT) begin
                work <= step_val;
                cnt  <= cnt - SHAMT_W'(1);
                if (last_step) begin
                    Out      <= step_val;
                    Zero     <= (step_val == '0);
                    Carry    <= step_bit;
                    Overflow <= 1'b0;
                    Negative <= step_val[WIDTH-1];
                    Err      <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: handshake timing, flags, iterative shifts, reset abort, errors.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic [3:0]  Op;
    logic [4:0]  shamt;
    logic        ready, done;
    logic [31:0] Out;
    logic        Zero, Carry, Overflow, Negative, Err;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Op(Op), .shamt(shamt),
        .ready(ready), .done(done), .Out(Out), .Zero(Zero), .Carry(Carry),
        .Overflow(Overflow), .Negative(Negative), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] sh);
        @(negedge clk);
        A = a; B = b; Op = op; shamt = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Op = OP_ADD; shamt = '0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else passed++;
        total++; if (Out !== 32'h0) $display("FAIL reset_out got=%h exp=0", Out); else passed++;
        total++;
        if ({Zero, Carry, Overflow, Negative, Err} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {Zero, Carry, Overflow, Negative, Err});
        else passed++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add;
        issue(32'h96F20BE5, 32'hB4AC2923, OP_ADD, 5'd0);
        total++; if (done !== 1'b1) $display("FAIL add_done got=%0b exp=1", done); else passed++;
        total++; if (Out !== 32'h4B9E3508) $display("FAIL add_out got=%h exp=4b9e3508", Out); else passed++;
        total++;
        if ({Zero, Carry, Overflow, Negative, Err} !== 5'b01100)
            $display("FAIL add_flags got=%b exp=01100", {Zero, Carry, Overflow, Negative, Err});
        else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL add_done_pulse got=%0b exp=0", done); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        A = 32'd5; B = 32'd5; Op = OP_SUB; start = 1'b1;
        @(negedge clk);
        A = 32'd3; B = 32'd5;
        total++; if (done !== 1'b1) $display("FAIL b2b_done1 got=%0b exp=1", done); else passed++;
        total++; if (Out !== 32'h0 || Zero !== 1'b1) $display("FAIL b2b_out1 got=%h z=%0b exp=0 z=1", Out, Zero); else passed++;
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL b2b_done2 got=%0b exp=1", done); else passed++;
        total++; if (Out !== 32'hFFFFFFFE) $display("FAIL b2b_out2 got=%h exp=fffffffe", Out); else passed++;
        total++;
        if ({Zero, Carry, Overflow, Negative, Err} !== 5'b01010)
            $display("FAIL b2b_flags2 got=%b exp=01010", {Zero, Carry, Overflow, Negative, Err});
        else passed++;
    endtask

    task automatic test_logic_and_zero_shift;
        issue(32'h0000F0F0, 32'h0000FF00, OP_AND, 5'd0);
        total++; if (Out !== 32'h0000F000) $display("FAIL and_out got=%h exp=0000f000", Out); else passed++;
        issue(32'h0F0F0F0F, 32'h0, OP_NOT, 5'd0);
        total++; if (Out !== 32'hF0F0F0F0 || Negative !== 1'b1) $display("FAIL not_out got=%h n=%0b exp=f0f0f0f0 n=1", Out, Negative); else passed++;
        issue(32'h80000001, 32'h0, OP_LSL, 5'd0);
        total++; if (done !== 1'b1 || ready !== 1'b1) $display("FAIL shamt0_done got=%0b/%0b exp=1/1", done, ready); else passed++;
        total++;
        if (Out !== 32'h80000001 || Carry !== 1'b0 || Negative !== 1'b1)
            $display("FAIL shamt0_out got=%h c=%0b n=%0b exp=80000001 c=0 n=1", Out, Carry, Negative);
        else passed++;
    endtask

    task automatic test_ror;
        logic bad;
        bad = 1'b0;
        issue(32'h000000F1, 32'h0, OP_ROR, 5'd4);
        for (int i = 1; i <= 4; i++) begin
            if (ready !== 1'b0 || done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        total++; if (bad) $display("FAIL ror_busy got=early_ready_or_done exp=busy_4_cycles"); else passed++;
        total++; if (done !== 1'b1 || ready !== 1'b1) $display("FAIL ror_done got=%0b/%0b exp=1/1", done, ready); else passed++;
        total++; if (Out !== 32'h1000000F || Carry !== 1'b0) $display("FAIL ror_out got=%h c=%0b exp=1000000f c=0", Out, Carry); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL ror_pulse got=%0b exp=0", done); else passed++;
    endtask

    task automatic test_asr_max;
        logic bad_busy, bad_out;
        bad_busy = 1'b0; bad_out = 1'b0;
        issue(32'h80000000, 32'h0, OP_ASR, 5'd31);
        for (int i = 1; i <= 31; i++) begin
            if (ready !== 1'b0 || done !== 1'b0) bad_busy = 1'b1;
            if (Out !== 32'h1000000F) bad_out = 1'b1;
            if (i == 5) begin A = 32'd1; B = 32'd1; Op = OP_ADD; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (bad_busy) $display("FAIL asr_busy got=early_ready_or_done exp=busy_31_cycles"); else passed++;
        total++; if (bad_out) $display("FAIL asr_hold got=changed exp=1000000f"); else passed++;
        total++; if (done !== 1'b1) $display("FAIL asr_done got=%0b exp=1", done); else passed++;
        total++;
        if (Out !== 32'hFFFFFFFF || Negative !== 1'b1 || Carry !== 1'b0 || Zero !== 1'b0)
            $display("FAIL asr_out got=%h n=%0b c=%0b z=%0b exp=ffffffff n=1 c=0 z=0", Out, Negative, Carry, Zero);
        else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0 || Out !== 32'hFFFFFFFF) $display("FAIL asr_ignored got=%0b/%h exp=0/ffffffff", done, Out); else passed++;
    endtask

    task automatic test_reset_mid_shift;
        logic saw_done;
        saw_done = 1'b0;
        issue(32'h1, 32'h0, OP_LSL, 5'd8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL rstmid_ctrl got=%0b/%0b exp=1/0", ready, done); else passed++;
        total++;
        if (Out !== 32'h0 || {Zero, Carry, Overflow, Negative, Err} !== 5'b0)
            $display("FAIL rstmid_data got=%h/%b exp=0/00000", Out, {Zero, Carry, Overflow, Negative, Err});
        else passed++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        total++; if (saw_done) $display("FAIL rstmid_nodone got=done_pulse exp=none"); else passed++;
        issue(32'd1, 32'd1, OP_ADD, 5'd0);
        total++; if (done !== 1'b1 || Out !== 32'd2) $display("FAIL rstmid_add got=%0b/%h exp=1/00000002", done, Out); else passed++;
    endtask

    task automatic test_err;
        issue(32'h12345678, 32'h9ABCDEF0, 4'b1111, 5'd3);
        total++; if (done !== 1'b1 || Out !== 32'h0) $display("FAIL err_out got=%0b/%h exp=1/0", done, Out); else passed++;
        total++;
        if ({Zero, Carry, Overflow, Negative, Err} !== 5'b10001)
            $display("FAIL err_flags got=%b exp=10001", {Zero, Carry, Overflow, Negative, Err});
        else passed++;
        issue(32'h00000010, 32'h00000001, OP_OR, 5'd0);
        total++; if (Err !== 1'b0 || Out !== 32'h00000011) $display("FAIL err_clear got=%0b/%h exp=0/00000011", Err, Out); else passed++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_logic_and_zero_shift;
        test_ror;
        test_asr_max;
        test_reset_mid_shift;
        test_err;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational ALU: WIDTH-bit datapath, start/ready/done handshake, full flag set (Zero, Carry, Overflow, Negative, Err) and multi-bit shifts/rotates executed iteratively one bit per cycle. It sits between the register-file read stage and write-back. The controller issues one operation when `ready` is high and captures results on `done`.

## Interface
- WIDTH, 32, datapath width in bits (≥ 4)
- SHAMT_W, $clog2(WIDTH), width of the shift-amount port
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only on an edge where `ready`=1
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Op  in  4  opcode (encodings under Operation)
- shamt  in  SHAMT_W  shift/rotate amount; ignored for other ops
- ready  out  1  idle, can accept `start`
- done  out  1  one-cycle pulse: `Out` and all flags are newly valid
- Out  out  WIDTH  result; holds until the next result
- Zero, Carry, Overflow, Negative, Err  out  1 each  result flags; hold with `Out`

## Operation
- Opcodes: 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 OR, 0100 NOT A, 1000 ASR, 1001 LSL, 1010 LSR, 1100 ROL, 1101 ROR; all others undefined.
- FSM states: IDLE (`ready`=1) and SHIFT (`ready`=0). A, Op and shamt are latched on accept; later input changes have no effect.
- Non-shift op, or shift with shamt=0: the result registers on the accept edge, FSM stays in IDLE. shamt=0 gives `Out`=A and Carry=0.
- Shift with shamt=n>0:
  - The accept edge loads the working register with A and the counter with n, then enters SHIFT.
  - Each edge in SHIFT moves the value one bit and decrements the counter.
  - The edge where the counter reaches 0 writes `Out` and the flags and returns to IDLE.
- ASR replicates the MSB. LSL/LSR shift in 0. ROL/ROR wrap the outgoing bit.
- Zero = (`Out`==0). Negative = `Out`[WIDTH−1].
- ADD: Carry = carry out; Overflow = signed overflow.
- SUB: Carry = borrow (A<B unsigned); Overflow = signed overflow.
- Shifts/rotates: Carry = last bit shifted out (the wrapped bit for rotates); Overflow = 0.
- Logic ops: Carry = Overflow = 0.
- Undefined opcode: `Out`=0, Zero=1, Err=1, other flags 0; completes in one cycle. Err=0 for all defined ops.
- `start` while `ready`=0 is ignored, neither queued nor flagged.

## Timing
- Reset values: `ready`=1, `done`=0, `Out`=0, all flags 0, FSM=IDLE, counter=0.
- Non-shift latency: `done` high in the cycle after the accept edge. Back-to-back accepts every cycle are allowed, and `done` stays high across consecutive results.
- Shift latency: n+1 edges from accept to result. `done` pulses for exactly one cycle, and `ready` rises in that same cycle.
- A new `start` is accepted on the edge that ends a `done` cycle, if `ready`=1.
- Reset asserted mid-SHIFT: immediate return to reset values; no `done` for the aborted op.
- Maximum shift (shamt=WIDTH−1) takes WIDTH edges; the counter never wraps.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_ADD … OP_ROR), the FSM state encoding, and a helper function `is_shift(op)`.
- One sub-module `alu_shift_step`: combinational one-bit ASR/LSL/LSR/ROL/ROR of a WIDTH-bit value, returning the shifted value and the outgoing bit. It is instantiated once inside the FSM datapath.
- All arithmetic is WIDTH+1 bits wide, so carry/borrow is taken from the extra bit.

## Test plan
- ADD, A=0x96F20BE5, B=0xB4AC2923, WIDTH=32 → one cycle later `done`=1, `Out`=0x4B9E3508, Carry=1, Overflow=1, Negative=0, Zero=0.
- SUB, A=5, B=5, then A=3, B=5 on back-to-back cycles → `Out`=0 with Zero=1, then `Out`=0xFFFFFFFE with Carry=1 and Negative=1; `done` high for two consecutive cycles.
- ROR, A=0x000000F1, shamt=4 → `ready`=0 for 4 cycles; `done` on the 5th cycle after accept; `Out`=0x1000000F, Carry=0.
- ASR, A=0x80000000, shamt=31 → `done` 32 cycles after accept; `Out`=0xFFFFFFFF, Negative=1. A `start` with Op=ADD mid-shift is ignored, and `Out` is unchanged until `done`.
- LSL, A=1, shamt=8; assert `rst` at the 3rd SHIFT cycle → `ready`=1, `Out`=0, flags 0, and no `done` pulse; the next ADD of 1+1 returns 2.
- Op=1111, any operands → one cycle later `Out`=0, Zero=1, Err=1; the next defined op clears Err.
